// File: rtl/alu_multicycle.sv
// alu_multicycle
//   Registered ALU for the multi-cycle RISC-V core. Single-cycle ops
//   (add/sub/logic/shifts/compares) complete one clock after they are
//   accepted. mul (low word) runs a shift-add loop and divu/remu run a
//   restoring divider. Both iterative ops take WIDTH+1 cycles from accept
//   to done.
//
// Ports
//   clk         rising-edge clock
//   reset       asynchronous, active-high reset
//   start       request, sampled only while busy = 0
//   a_in, b_in  operands, captured on accept
//   ALUControl  4-bit op select, captured on accept
//   ALUResult   registered result, held until the next completion
//   Z           registered (ALUResult == 0), updated together with ALUResult
//   busy        high while mul/divu/remu is iterating
//   done        one-cycle pulse when ALUResult/Z are updated
module alu_multicycle #(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] b_in,
    input  logic [3:0]       ALUControl,
    output logic [WIDTH-1:0] ALUResult,
    output logic             Z,
    output logic             busy,
    output logic             done
);

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_AND  = 4'b0010;
    localparam logic [3:0] OP_XOR  = 4'b0011;
    localparam logic [3:0] OP_SLL  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_OR   = 4'b0110;
    localparam logic [3:0] OP_SLTU = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;
    localparam logic [3:0] OP_SRA  = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_DIVU = 4'b1011;
    localparam logic [3:0] OP_REMU = 4'b1100;

    localparam logic [SHAMT_W-1:0] CNT_LOAD = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t             state_reg;
    logic [SHAMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0]   mcand_reg;
    logic [WIDTH-1:0]   mplier_reg;
    logic [WIDTH-1:0]   acc_reg;
    logic [WIDTH-1:0]   dvd_reg;      // dividend bits shift out, quotient bits shift in
    logic [WIDTH-1:0]   divisor_reg;
    logic [WIDTH:0]     rem_reg;
    logic               is_rem_reg;

    // Single-cycle datapath, straight from the live inputs.
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   sc_result;

    assign shamt = b_in[SHAMT_W-1:0];

    always_comb begin
        sc_result = '0;
        case (ALUControl)
            OP_ADD:  sc_result = a_in + b_in;
            OP_SUB:  sc_result = a_in + ~b_in + WIDTH'(1);
            OP_AND:  sc_result = a_in & b_in;
            OP_XOR:  sc_result = a_in ^ b_in;
            OP_SLL:  sc_result = a_in << shamt;
            OP_SLT:  sc_result = {{(WIDTH-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
            OP_OR:   sc_result = a_in | b_in;
            OP_SLTU: sc_result = {{(WIDTH-1){1'b0}}, (a_in < b_in)};
            OP_SRL:  sc_result = a_in >> shamt;
            OP_SRA:  sc_result = $signed(a_in) >>> shamt;
            default: sc_result = '0;   // reserved codes
        endcase
    end

    // One shift-add multiply step (LSB-first multiplier).
    logic [WIDTH-1:0] acc_next;
    assign acc_next = acc_reg + (mplier_reg[0] ? mcand_reg : '0);

    // One restoring divide step. The shifted partial remainder needs the
    // extra bit so the compare against the divisor never overflows.
    logic [WIDTH:0]   rem_shift;
    logic             rem_ge;
    logic [WIDTH:0]   rem_next;
    logic [WIDTH-1:0] quo_next;

    assign rem_shift = (rem_reg << 1) | {{WIDTH{1'b0}}, dvd_reg[WIDTH-1]};
    assign rem_ge    = rem_shift >= {1'b0, divisor_reg};
    assign rem_next  = rem_ge ? (rem_shift - {1'b0, divisor_reg}) : rem_shift;
    assign quo_next  = {dvd_reg[WIDTH-2:0], rem_ge};

    logic [WIDTH-1:0] div_result;
    assign div_result = is_rem_reg ? rem_next[WIDTH-1:0] : quo_next;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            mcand_reg   <= '0;
            mplier_reg  <= '0;
            acc_reg     <= '0;
            dvd_reg     <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            is_rem_reg  <= 1'b0;
            ALUResult   <= '0;
            Z           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        if (ALUControl == OP_MUL) begin
                            mcand_reg  <= a_in;
                            mplier_reg <= b_in;
                            acc_reg    <= '0;
                            cnt_reg    <= CNT_LOAD;
                            busy       <= 1'b1;
                            state_reg  <= MUL;
                        end else if (ALUControl == OP_DIVU || ALUControl == OP_REMU) begin
                            dvd_reg     <= a_in;
                            divisor_reg <= b_in;
                            rem_reg     <= '0;
                            is_rem_reg  <= (ALUControl == OP_REMU);
                            cnt_reg     <= CNT_LOAD;
                            busy        <= 1'b1;
                            state_reg   <= DIV;
                        end else begin
                            ALUResult <= sc_result;
                            Z         <= (sc_result == '0);
                            done      <= 1'b1;
                        end
                    end
                end
                MUL: begin
                    acc_reg    <= acc_next;
                    mcand_reg  <= mcand_reg << 1;
                    mplier_reg <= mplier_reg >> 1;
                    cnt_reg    <= cnt_reg - 1'b1;
                    // Last step: the result is taken from the step's own output.
                    if (cnt_reg == '0) begin
                        ALUResult <= acc_next;
                        Z         <= (acc_next == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                DIV: begin
                    rem_reg <= rem_next;
                    dvd_reg <= quo_next;
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == '0) begin
                        ALUResult <= div_result;
                        Z         <= (div_result == '0);
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    busy      <= 1'b0;
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_multicycle.sv
// Directed testbench for alu_multicycle (WIDTH=32). Inputs are driven 1 ns
// after the rising edge and outputs are sampled at the same point.
module tb_alu_multicycle;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] a_in;
    logic [31:0] b_in;
    logic [3:0]  ALUControl;
    logic [31:0] ALUResult;
    logic        Z;
    logic        busy;
    logic        done;

    int n_checks = 0;
    int n_errors = 0;

    alu_multicycle #(.WIDTH(32)) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a_in       (a_in),
        .b_in       (b_in),
        .ALUControl (ALUControl),
        .ALUResult  (ALUResult),
        .Z          (Z),
        .busy       (busy),
        .done       (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request for one cycle; returns just after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        start      = 1'b1;
        ALUControl = op;
        a_in       = a;
        b_in       = b;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Issue an op, wait for done (bounded), check latency, busy length,
    // result, Z and that done falls again one cycle later.
    task automatic run_op(input string name, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] exp_res, input logic exp_z,
                          input int exp_lat, input int exp_busy);
        int cycles;
        int busy_cnt;
        issue(op, a, b);
        cycles   = 1;
        busy_cnt = busy ? 1 : 0;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (busy) busy_cnt++;
        end
        check({name, "_done"}, {31'b0, done}, 32'd1);
        check({name, "_latency"}, cycles, exp_lat);
        check({name, "_busy_cycles"}, busy_cnt, exp_busy);
        check({name, "_result"}, ALUResult, exp_res);
        check({name, "_z"}, {31'b0, Z}, {31'b0, exp_z});
        $display("%s a=%h b=%h -> %h z=%0d lat=%0d", name, a, b, ALUResult, Z, cycles);
        @(posedge clk);
        #1;
        check({name, "_done_pulse"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        int cycles;
        int done_cnt;

        reset      = 1'b1;
        start      = 1'b0;
        a_in       = '0;
        b_in       = '0;
        ALUControl = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_result", ALUResult, 32'd0);
        check("reset_z", {31'b0, Z}, 32'd0);
        check("reset_busy", {31'b0, busy}, 32'd0);
        check("reset_done", {31'b0, done}, 32'd0);
        reset = 1'b0;

        // Single-cycle ops
        run_op("add",   4'b0000, 32'd5,        32'd7,  32'd12,       1'b0, 1, 0);
        run_op("sub",   4'b0001, 32'd7,        32'd7,  32'd0,        1'b1, 1, 0);
        run_op("and",   4'b0010, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 1'b0, 1, 0);
        run_op("xor",   4'b0011, 32'h0000F0F0, 32'h0000FF00, 32'h00000FF0, 1'b0, 1, 0);
        run_op("or",    4'b0110, 32'h0000F0F0, 32'h0000FF00, 32'h0000FFF0, 1'b0, 1, 0);
        run_op("slt",   4'b0101, 32'hFFFFFFFF, 32'd1,  32'd1,        1'b0, 1, 0);
        run_op("sltu",  4'b0111, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b1, 1, 0);
        run_op("sra",   4'b1001, 32'h80000000, 32'd4,  32'hF8000000, 1'b0, 1, 0);
        run_op("srl",   4'b1000, 32'h80000000, 32'd4,  32'h08000000, 1'b0, 1, 0);
        run_op("sll",   4'b0100, 32'd1,        32'd33, 32'd2,        1'b0, 1, 0);
        run_op("rsvd",  4'b1101, 32'd5,        32'd7,  32'd0,        1'b1, 1, 0);

        // Iterative ops: 33-cycle latency, busy for 32 cycles
        run_op("mul_a", 4'b1010, 32'h00010001, 32'h00010001, 32'h00020001, 1'b0, 33, 32);
        run_op("mul_b", 4'b1010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1'b0, 33, 32);
        run_op("divu",  4'b1011, 32'd100,      32'd7,  32'd14,       1'b0, 33, 32);
        run_op("remu",  4'b1100, 32'd100,      32'd7,  32'd2,        1'b0, 33, 32);
        run_op("divu0", 4'b1011, 32'd5,        32'd0,  32'hFFFFFFFF, 1'b0, 33, 32);
        run_op("remu0", 4'b1100, 32'd5,        32'd0,  32'd5,        1'b0, 33, 32);
        run_op("divu1", 4'b1011, 32'hFFFFFFFF, 32'd1,  32'hFFFFFFFF, 1'b0, 33, 32);
        run_op("remu1", 4'b1100, 32'hFFFFFFFF, 32'd1,  32'd0,        1'b1, 33, 32);

        // Handshake: start during busy is ignored, inputs may change freely
        issue(4'b1011, 32'd100, 32'd7);
        start      = 1'b1;
        ALUControl = 4'b0000;
        a_in       = 32'd1;
        b_in       = 32'd2;
        @(posedge clk);
        #1;
        start = 1'b0;
        a_in  = 32'hDEADBEEF;
        b_in  = 32'h00000003;
        cycles = 2;
        while (!done && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
        end
        check("hs_div_latency", cycles, 33);
        check("hs_div_result", ALUResult, 32'd14);
        $display("hs_divu ignored add during busy -> %h lat=%0d", ALUResult, cycles);
        // add issued on the divu done cycle
        issue(4'b0000, 32'd3, 32'd4);
        check("hs_add_done", {31'b0, done}, 32'd1);
        check("hs_add_result", ALUResult, 32'd7);
        $display("hs_add on done cycle -> %h", ALUResult);
        @(posedge clk);
        #1;

        // Reset in the middle of a mul
        issue(4'b1010, 32'd3, 32'd5);
        repeat (9) @(posedge clk);
        #1;
        check("rst_mid_busy_before", {31'b0, busy}, 32'd1);
        reset = 1'b1;
        #1;
        check("rst_mid_result", ALUResult, 32'd0);
        check("rst_mid_z", {31'b0, Z}, 32'd0);
        check("rst_mid_busy", {31'b0, busy}, 32'd0);
        check("rst_mid_done", {31'b0, done}, 32'd0);
        $display("reset during mul -> result=%h busy=%0d", ALUResult, busy);
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_op("add_after_rst", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1, 0);
        done_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (done || busy) done_cnt++;
        end
        check("rst_no_late_done", done_cnt, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
